ula_src_ctrl: RTL

- Sequencing FSM that drives the ALU operand-select muxes (source A and source B) and the ALU operation for the multicycle datapath.
- Also drives the related write strobes (PC, ALUOut, IR, memory read).
- Sits between the main control unit, which issues one command per request via a start/done handshake, and the datapath muxes and registers, which consume its Moore outputs.
- Handles the memory wait on instruction fetch with a bounded timeout.

---
 rtl/ula_ctrl_pkg.sv | 34 +++
 rtl/ula_src_ctrl_if.sv | 35 +++
 rtl/ula_wait_cnt.sv | 28 ++
 rtl/ula_src_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/ula_ctrl_pkg.sv
// Shared encodings for the ALU source-select sequencer and the operand muxes.
package ula_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_PC_INC  = 3'd2,
    ST_BR_ADDR = 3'd3,
    ST_EXEC    = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERR     = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    CMD_FETCH       = 2'b00,
    CMD_BRANCH_ADDR = 2'b01,
    CMD_EXEC        = 2'b10,
    CMD_CLEAR       = 2'b11
  } cmd_t;

  // Source-A mux codes
  localparam logic [1:0] SRC_A_PC   = 2'b00;
  localparam logic [1:0] SRC_A_REG  = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;

  // Source-B mux codes
  localparam logic [1:0] SRC_B_REG      = 2'b00;
  localparam logic [1:0] SRC_B_FOUR     = 2'b01;
  localparam logic [1:0] SRC_B_IMM      = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SHL2 = 2'b11;

  localparam logic [2:0] ULA_OP_ADD = 3'b001;

endpackage

// File: rtl/ula_src_ctrl_if.sv
// Command handshake plus datapath control bundle of the ALU source sequencer.
interface ula_src_ctrl_if;
  import ula_ctrl_pkg::*;

  logic       start;
  logic [1:0] cmd;
  logic [2:0] exec_op;
  logic       exec_src_imm;
  logic       mem_ready;
  logic [1:0] sel_ula1;
  logic [1:0] sel_ula2;
  logic [2:0] ula_op;
  logic       mem_read;
  logic       ir_write;
  logic       pc_write;
  logic       aluout_write;
  logic       busy;
  logic       done;
  logic       err;

  // Control unit / memory side
  modport master (
    output start, cmd, exec_op, exec_src_imm, mem_ready,
    input  sel_ula1, sel_ula2, ula_op, mem_read, ir_write, pc_write,
           aluout_write, busy, done, err
  );

  // Sequencer side
  modport slave (
    input  start, cmd, exec_op, exec_src_imm, mem_ready,
    output sel_ula1, sel_ula2, ula_op, mem_read, ir_write, pc_write,
           aluout_write, busy, done, err
  );

endinterface

// File: rtl/ula_wait_cnt.sv
// Saturating memory-wait counter with clear, enable and expiry compare.
module ula_wait_cnt #(
  parameter int unsigned MEM_WAIT_MAX = 8,
  parameter int unsigned WAIT_W       = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  logic [WAIT_W-1:0] cnt;

  // Count waiting cycles; hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + WAIT_W'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/ula_src_ctrl.sv
// Multicycle ALU source/op sequencer driven by a start/done command handshake.
module ula_src_ctrl
  import ula_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 8,
  parameter int unsigned WAIT_W       = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  ula_src_ctrl_if.slave     bus
);

  state_t     state;
  cmd_t       cmd_q;
  logic [2:0] op_q;
  logic       imm_q;
  logic       wait_expired;
  logic       wait_clr;
  logic       wait_en;

  // Counter is cleared on either FETCH exit so every fetch starts from zero.
  assign wait_clr = (state == ST_FETCH) && (bus.mem_ready || wait_expired);
  assign wait_en  = (state == ST_FETCH) && !bus.mem_ready;

  ula_wait_cnt #(
    .MEM_WAIT_MAX (MEM_WAIT_MAX),
    .WAIT_W       (WAIT_W)
  ) u_wait_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (wait_clr),
    .en      (wait_en),
    .expired (wait_expired)
  );

  // State sequencing and command latching.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cmd_q <= CMD_FETCH;
      op_q  <= '0;
      imm_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            cmd_q <= cmd_t'(bus.cmd);
            op_q  <= bus.exec_op;
            imm_q <= bus.exec_src_imm;
            case (cmd_t'(bus.cmd))
              CMD_FETCH:       state <= ST_FETCH;
              CMD_BRANCH_ADDR: state <= ST_BR_ADDR;
              default:         state <= ST_EXEC;
            endcase
          end
        end
        ST_FETCH: begin
          // mem_ready wins over the timeout on the last allowed cycle
          if (bus.mem_ready)      state <= ST_PC_INC;
          else if (wait_expired)  state <= ST_ERR;
        end
        ST_PC_INC,
        ST_BR_ADDR,
        ST_EXEC:  state <= ST_DONE;
        ST_DONE,
        ST_ERR:   state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Moore output decode of the registered state; ir_write additionally
  // follows mem_ready while fetching so IR captures the valid read data.
  always_comb begin
    bus.sel_ula1     = SRC_A_PC;
    bus.sel_ula2     = SRC_B_REG;
    bus.ula_op       = '0;
    bus.mem_read     = 1'b0;
    bus.ir_write     = 1'b0;
    bus.pc_write     = 1'b0;
    bus.aluout_write = 1'b0;
    bus.busy         = 1'b1;
    bus.done         = 1'b0;
    bus.err          = 1'b0;
    case (state)
      ST_IDLE: bus.busy = 1'b0;
      ST_FETCH: begin
        bus.mem_read = 1'b1;
        bus.ir_write = bus.mem_ready;
      end
      ST_PC_INC: begin
        bus.sel_ula1 = SRC_A_PC;
        bus.sel_ula2 = SRC_B_FOUR;
        bus.ula_op   = ULA_OP_ADD;
        bus.pc_write = 1'b1;
      end
      ST_BR_ADDR: begin
        bus.sel_ula1     = SRC_A_PC;
        bus.sel_ula2     = SRC_B_IMM_SHL2;
        bus.ula_op       = ULA_OP_ADD;
        bus.aluout_write = 1'b1;
      end
      ST_EXEC: begin
        bus.aluout_write = 1'b1;
        if (cmd_q == CMD_CLEAR) begin
          bus.sel_ula1 = SRC_A_ZERO;
          bus.sel_ula2 = SRC_B_REG;
          bus.ula_op   = ULA_OP_ADD;
        end else begin
          bus.sel_ula1 = SRC_A_REG;
          bus.sel_ula2 = imm_q ? SRC_B_IMM : SRC_B_REG;
          bus.ula_op   = op_q;
        end
      end
      ST_DONE: bus.done = 1'b1;
      ST_ERR: begin
        bus.done = 1'b1;
        bus.err  = 1'b1;
      end
      default: bus.busy = 1'b0;
    endcase
  end

endmodule
